uart_cmd_receiver: RTL and testbench
====================================

UART_CMD_RECEIVER -- requirements
Module: uart_cmd_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (5208 at defaults), integer division.
REQ-003 SHALL have parameter HEADER, default 2'b10, required value of command byte bits [7:6].
REQ-004 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 uart_in  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-007 data_out  output  8  last correctly framed byte.
REQ-008 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-009 framing_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 direction  output  3  last accepted direction command, byte bits [5:3].
REQ-011 speed  output  3  last accepted speed command, byte bits [2:0].
REQ-012 cmd_valid  output  1  one-cycle pulse when direction/speed update.
REQ-013 cmd_error  output  1  one-cycle pulse when a framed byte has a wrong header.

Function
REQ-014 uart_in SHALL pass through a 2-flop synchronizer before use; all timing below is measured from the synchronized signal (2-cycle input latency).
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE: on synchronized line low, SHALL clear the bit-timer and enter START.
REQ-017 START: after CLKS_PER_BIT/2 cycles, SHALL sample; low -> DATA with bit index 0; high -> IDLE as a glitch, with no output pulse.
REQ-018 DATA: SHALL sample every CLKS_PER_BIT cycles, shifting LSB first; after the 8th sample SHALL enter STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles, SHALL sample; high -> data_out loaded and data_valid pulsed on the next cycle, then IDLE; low -> framing_error pulsed, data_out held, then WAIT_HIGH.
REQ-020 WAIT_HIGH: SHALL remain in this state until the synchronized line is high, then enter IDLE (break condition; no new start detected while low).
REQ-021 Decode SHALL occur in the same cycle as data_valid: if byte[7:6]==HEADER, direction<=byte[5:3], speed<=byte[2:0], cmd_valid=1; else cmd_error=1 and direction/speed are held.
REQ-022 data_valid and framing_error SHALL never assert in the same cycle; cmd_valid and cmd_error SHALL only assert coincident with data_valid.
REQ-023 A start edge arriving in the cycle after return to IDLE SHALL be accepted, so back-to-back frames with no idle gap are received without loss.
REQ-024 Bit-timer width SHALL be $clog2(CLKS_PER_BIT)+1; the timer SHALL never wrap within a bit period.
REQ-025 All pulses SHALL be exactly one CLOCK_50 cycle wide.

Reset
REQ-026 On reset assertion, outputs SHALL immediately become: data_out=0, data_valid=0, framing_error=0, direction=3'b000 (stop), speed=0, cmd_valid=0, cmd_error=0; synchronizer flops SHALL be 1; FSM SHALL be IDLE; timer and bit index SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception SHALL resume only on a fresh falling edge.

Verification
REQ-028 Send 8N1 frame 0x9A at 9600 baud -> data_out=0x9A, data_valid pulse, cmd_valid pulse, direction=3'b011, speed=3'b010.
REQ-029 Send frame 0x5A -> data_valid pulse, data_out=0x5A, cmd_error pulse, direction/speed unchanged from previous values.
REQ-030 Send frame 0x81 with stop bit forced low, then hold the line low for 3 bit periods -> framing_error pulse only; no data_valid; no frame detected until the line returns high.
REQ-031 Drive a 1000-cycle low glitch -> no pulses; FSM back in IDLE; a following frame 0x88 decodes with direction=3'b001, speed=3'b000.
REQ-032 Send back-to-back frames 0x91, 0xA7 with zero idle gap -> two data_valid pulses about 52080 cycles apart; final state direction=3'b100, speed=3'b111.
REQ-033 Assert reset during bit 4 of a frame -> outputs at reset values; remaining bits ignored; next full frame 0x9A decodes correctly.

Source files
------------

// File: rtl/uart_cmd_receiver.sv
// rtl/uart_cmd_receiver.sv - 8N1 UART receiver with header-checked direction/speed command decode
module uart_cmd_receiver #(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 9600,
    parameter logic [1:0] HEADER   = 2'b10
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       uart_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_error,
    output logic [2:0] direction,
    output logic [2:0] speed,
    output logic       cmd_valid,
    output logic       cmd_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_next;
    logic          sync_meta, sync_rx;
    logic [1:0]    sync_fill;
    logic          armed;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          timer_clr, shift_en, stop_good, stop_bad, hdr_ok;

    // The synchronizer resets high, so its first two outputs after reset are not
    // real line samples; a start is only armed once the true line has been seen high.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_rx   <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync_meta <= uart_in;
            sync_rx   <= sync_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && sync_rx)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        shift_en   = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !sync_rx) begin
                    timer_clr  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (timer == HALF_LAST) begin
                    timer_clr  = 1'b1;
                    state_next = sync_rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == FULL_LAST) begin
                    timer_clr = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_idx == 3'd7)
                        state_next = STOP;
                end
            end
            STOP: begin
                if (timer == FULL_LAST) begin
                    timer_clr = 1'b1;
                    if (sync_rx) begin
                        stop_good  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (sync_rx)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Timer is cleared on its terminal count, so it never wraps inside a bit period.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            if (timer_clr)
                timer <= '0;
            else if (state == START || state == DATA || state == STOP)
                timer <= timer + 1'b1;

            if (state == IDLE)
                bit_idx <= 3'd0;
            else if (shift_en)
                bit_idx <= bit_idx + 3'd1;

            if (shift_en)
                shift_reg <= {sync_rx, shift_reg[7:1]};
        end
    end

    assign hdr_ok = (shift_reg[7:6] == HEADER);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            direction     <= 3'b000;
            speed         <= 3'b000;
            cmd_valid     <= 1'b0;
            cmd_error     <= 1'b0;
        end else begin
            data_valid    <= stop_good;
            framing_error <= stop_bad;
            cmd_valid     <= stop_good && hdr_ok;
            cmd_error     <= stop_good && !hdr_ok;
            if (stop_good)
                data_out <= shift_reg;
            if (stop_good && hdr_ok) begin
                direction <= shift_reg[5:3];
                speed     <= shift_reg[2:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// tb/tb_uart_cmd_receiver.sv - directed table-driven bench for uart_cmd_receiver
module tb_uart_cmd_receiver;

    localparam int CLK_FREQ = 640_000;
    localparam int BAUD     = 10_000;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, framing_error, cmd_valid, cmd_error;
    logic [2:0] direction, speed;

    uart_cmd_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .HEADER(2'b10)) dut (
        .CLOCK_50      (clk),
        .reset         (rst),
        .uart_in       (uart_in),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .direction     (direction),
        .speed         (speed),
        .cmd_valid     (cmd_valid),
        .cmd_error     (cmd_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dv_cnt = 0, cv_cnt = 0, ce_cnt = 0, fe_cnt = 0, viol = 0;
    int last_dv = 0, prev_dv = 0;
    logic dv_q = 1'b0, fe_q = 1'b0, cv_q = 1'b0, ce_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt++;
            prev_dv = last_dv;
            last_dv = cyc;
        end
        if (cmd_valid)     cv_cnt++;
        if (cmd_error)     ce_cnt++;
        if (framing_error) fe_cnt++;
        if (data_valid && framing_error) viol++;
        if ((cmd_valid || cmd_error) && !data_valid) viol++;
        if ((data_valid && dv_q) || (framing_error && fe_q) ||
            (cmd_valid && cv_q) || (cmd_error && ce_q)) viol++;
        dv_q = data_valid;
        fe_q = framing_error;
        cv_q = cmd_valid;
        ce_q = cmd_error;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_in = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] byte_val;
        logic       stop_bit;
        int         dv, cv, ce, fe;
        logic [7:0] exp_data;
        logic [2:0] exp_dir;
        logic [2:0] exp_spd;
    } vec_t;

    vec_t vecs[6];
    int s_dv, s_cv, s_ce, s_fe;

    task automatic snap();
        s_dv = dv_cnt; s_cv = cv_cnt; s_ce = ce_cnt; s_fe = fe_cnt;
    endtask

    initial begin
        vecs[0] = '{8'h9A, 1'b1, 1, 1, 0, 0, 8'h9A, 3'b011, 3'b010};
        vecs[1] = '{8'h5A, 1'b1, 1, 0, 1, 0, 8'h5A, 3'b011, 3'b010};
        vecs[2] = '{8'hBF, 1'b1, 1, 1, 0, 0, 8'hBF, 3'b111, 3'b111};
        vecs[3] = '{8'h81, 1'b0, 0, 0, 0, 1, 8'hBF, 3'b111, 3'b111};
        vecs[4] = '{8'hC0, 1'b1, 1, 0, 1, 0, 8'hC0, 3'b111, 3'b111};
        vecs[5] = '{8'h80, 1'b1, 1, 1, 0, 0, 8'h80, 3'b000, 3'b000};

        repeat (3) @(negedge clk);
        check("reset_outputs", {data_out, direction, speed, data_valid, framing_error, cmd_valid, cmd_error},
              32'h0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        check("idle_no_pulses", dv_cnt + fe_cnt + cv_cnt + ce_cnt, 0);

        for (int v = 0; v < 6; v++) begin
            snap();
            send_frame(vecs[v].byte_val, vecs[v].stop_bit);
            uart_in = 1'b1;
            repeat (CPB) @(negedge clk);
            check($sformatf("v%0d_dv", v), dv_cnt - s_dv, vecs[v].dv);
            check($sformatf("v%0d_cv", v), cv_cnt - s_cv, vecs[v].cv);
            check($sformatf("v%0d_ce", v), ce_cnt - s_ce, vecs[v].ce);
            check($sformatf("v%0d_fe", v), fe_cnt - s_fe, vecs[v].fe);
            check($sformatf("v%0d_data", v), data_out, vecs[v].exp_data);
            check($sformatf("v%0d_dir", v), direction, vecs[v].exp_dir);
            check($sformatf("v%0d_spd", v), speed, vecs[v].exp_spd);
        end

        // framing error followed by a held-low break
        snap();
        send_frame(8'h81, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        check("brk_fe", fe_cnt - s_fe, 1);
        check("brk_no_dv", dv_cnt - s_dv, 0);
        uart_in = 1'b1;
        repeat (CPB) @(negedge clk);
        check("brk_quiet_after_high", (dv_cnt - s_dv) + (fe_cnt - s_fe), 1);
        snap();
        send_frame(8'hA5, 1'b1);
        uart_in = 1'b1;
        repeat (CPB) @(negedge clk);
        check("after_brk_dv", dv_cnt - s_dv, 1);
        check("after_brk_dir_spd", {direction, speed}, {3'b100, 3'b101});

        // short low glitch shorter than half a bit
        snap();
        uart_in = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_no_pulses", (dv_cnt - s_dv) + (fe_cnt - s_fe) + (cv_cnt - s_cv) + (ce_cnt - s_ce), 0);
        send_frame(8'h88, 1'b1);
        uart_in = 1'b1;
        repeat (CPB) @(negedge clk);
        check("glitch_next_dv", dv_cnt - s_dv, 1);
        check("glitch_next_dir_spd", {direction, speed}, {3'b001, 3'b000});

        // back-to-back frames with no idle gap
        snap();
        send_frame(8'h91, 1'b1);
        send_frame(8'hA7, 1'b1);
        uart_in = 1'b1;
        repeat (CPB) @(negedge clk);
        check("b2b_dv", dv_cnt - s_dv, 2);
        check("b2b_cv", cv_cnt - s_cv, 2);
        check("b2b_interval", last_dv - prev_dv, 10 * CPB);
        check("b2b_dir_spd", {direction, speed}, {3'b100, 3'b111});
        check("b2b_data", data_out, 8'hA7);

        // reset in the middle of bit 4 of an all-zero frame
        snap();
        uart_in = 1'b0;
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs", {data_out, direction, speed, data_valid, framing_error, cmd_valid, cmd_error},
              32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4 * CPB - CPB / 2) @(negedge clk);
        uart_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("midrst_no_pulses", (dv_cnt - s_dv) + (fe_cnt - s_fe), 0);
        snap();
        send_frame(8'h9A, 1'b1);
        uart_in = 1'b1;
        repeat (CPB) @(negedge clk);
        check("midrst_next_dv", dv_cnt - s_dv, 1);
        check("midrst_next_cmd", {data_out, direction, speed}, {8'h9A, 3'b011, 3'b010});

        check("pulse_rules", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
